// File: rtl/jogo_pkg.sv
// jogo_pkg: constants shared by the game blocks and the shot FSM encoding.
package jogo_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    VOANDO  = 2'd1,
    RECARGA = 2'd2
  } estado_tiro_t;

  localparam int LARG_AREA = 640;
  localparam int ALT_AREA  = 480;

  localparam int LARG_SPRITE_INIMIGO = 11;
  localparam int ALT_SPRITE_INIMIGO  = 8;
  localparam int ESCALA_INIMIGO      = 3;
  localparam int LARG_INIMIGO_PADRAO = LARG_SPRITE_INIMIGO * ESCALA_INIMIGO;
  localparam int ALT_INIMIGO_PADRAO  = ALT_SPRITE_INIMIGO * ESCALA_INIMIGO;

  localparam logic [9:0] PONTUACAO_MAX = 10'd1023;

  // inclusive base <= v <= base+tam, widened to 11 bits so base+tam cannot wrap
  function automatic logic dentro_faixa(input logic [9:0] v,
                                        input logic [9:0] base,
                                        input logic [9:0] tam);
    logic [10:0] v11;
    logic [10:0] lo11;
    logic [10:0] hi11;
    v11  = {1'b0, v};
    lo11 = {1'b0, base};
    hi11 = {1'b0, base} + {1'b0, tam};
    return (v11 >= lo11) && (v11 <= hi11);
  endfunction

endpackage

// File: rtl/controle_tiro_if.sv
// controle_tiro_if: game-side inputs and renderer-side outputs of the shot controller.
interface controle_tiro_if;
  logic       ativo;
  logic       botao_tiro;
  logic       reviver;
  logic [9:0] x_nave;
  logic [9:0] y_nave;
  logic [9:0] largura_nave;
  logic [9:0] x_inimigo;
  logic [9:0] y_inimigo;
  logic [9:0] x_bola_aliada;
  logic [9:0] y_bola_aliada;
  logic [9:0] raio_bola_aliada;
  logic       tiro_ativo;
  logic       inimigo_vivo;
  logic       acerto;
  logic [9:0] pontuacao;

  modport master (
    output ativo, botao_tiro, reviver, x_nave, y_nave, largura_nave, x_inimigo, y_inimigo,
    input  x_bola_aliada, y_bola_aliada, raio_bola_aliada, tiro_ativo, inimigo_vivo,
           acerto, pontuacao
  );

  modport slave (
    input  ativo, botao_tiro, reviver, x_nave, y_nave, largura_nave, x_inimigo, y_inimigo,
    output x_bola_aliada, y_bola_aliada, raio_bola_aliada, tiro_ativo, inimigo_vivo,
           acerto, pontuacao
  );
endinterface

// File: rtl/divisor_tick.sv
// divisor_tick: free-running 0..DIV-1 counter, tick high while the count is DIV-1.
module divisor_tick #(
  parameter int DIV = 250000
) (
  input  logic CLOCK_50,
  input  logic reset,
  output logic tick
);

  localparam int          W      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] ULTIMO = W'(DIV - 1);

  logic [W-1:0] contagem;

  // wrap at DIV-1, never stops
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)                  contagem <= '0;
    else if (contagem == ULTIMO) contagem <= '0;
    else                        contagem <= contagem + 1'b1;
  end

  assign tick = (contagem == ULTIMO);

endmodule

// File: rtl/controle_tiro.sv
// controle_tiro: ally shot controller (fire detect, upward motion, enemy hit, score).
// Build option: CONTROLE_TIRO_RECARGA_EN adds the post-shot cooldown state.
//
// state   | meaning
// OCIOSO  | no shot; spawn point tracks the ship nose, waits for a fire press
// VOANDO  | shot on screen, moves up PASSO px per tick, x frozen
// RECARGA | cooldown of RECARGA_TICKS ticks after a shot ends
module controle_tiro
  import jogo_pkg::*;
#(
  parameter int TICK_DIV      = 250000,
  parameter int PASSO         = 4,
  parameter int RAIO          = 3,
  parameter int LARG_INIMIGO  = LARG_INIMIGO_PADRAO,
  parameter int ALT_INIMIGO   = ALT_INIMIGO_PADRAO,
  parameter int RECARGA_TICKS = 50
) (
  input logic            CLOCK_50,
  input logic            reset,
  controle_tiro_if.slave bus
);

  localparam logic [9:0] PASSO_V = 10'(PASSO);
  localparam logic [9:0] RAIO_V  = 10'(RAIO);
  localparam logic [9:0] LARG_V  = 10'(LARG_INIMIGO);
  localparam logic [9:0] ALT_V   = 10'(ALT_INIMIGO);

`ifdef CONTROLE_TIRO_RECARGA_EN
  localparam int           W_REC      = (RECARGA_TICKS > 0) ? $clog2(RECARGA_TICKS + 1) : 1;
  localparam estado_tiro_t ESTADO_FIM = RECARGA;
  logic [W_REC-1:0] cnt_recarga;
`else
  localparam estado_tiro_t ESTADO_FIM = OCIOSO;
  localparam int           RECARGA_TICKS_UNUSED = RECARGA_TICKS;
`endif

  estado_tiro_t estado, prox_estado;
  logic         sinc0, sinc1, botao_ant, disparo;
  logic         tick;
  logic [9:0]   x_bola, y_bola, y_desc, pontuacao;
  logic         acerto, inimigo_vivo;
  logic         saiu, acertou, evento_acerto, mover;

  divisor_tick #(.DIV(TICK_DIV)) u_divisor (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .tick     (tick)
  );

  assign y_desc  = y_bola - PASSO_V;
  assign saiu    = (y_bola <= PASSO_V);
  assign acertou = inimigo_vivo &&
                   dentro_faixa(x_bola, bus.x_inimigo, LARG_V) &&
                   dentro_faixa(y_desc, bus.y_inimigo, ALT_V);

  // synchronize the button and register its rising edge as a one-cycle disparo
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sinc0     <= 1'b0;
      sinc1     <= 1'b0;
      botao_ant <= 1'b0;
      disparo   <= 1'b0;
    end else begin
      sinc0     <= bus.botao_tiro;
      sinc1     <= sinc0;
      botao_ant <= sinc1;
      disparo   <= sinc1 & ~botao_ant;
    end
  end

  // state register
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) estado <= OCIOSO;
    else       estado <= prox_estado;
  end

  // next state; ativo low overrides everything, including a pending hit
  always_comb begin
    prox_estado   = estado;
    evento_acerto = 1'b0;
    mover         = 1'b0;
    if (!bus.ativo) begin
      prox_estado = OCIOSO;
    end else begin
      case (estado)
        OCIOSO: if (disparo) prox_estado = VOANDO;
        VOANDO: begin
          if (tick) begin
            if (saiu) begin
              prox_estado = ESTADO_FIM;
            end else begin
              mover = 1'b1;
              if (acertou) begin
                evento_acerto = 1'b1;
                prox_estado   = ESTADO_FIM;
              end
            end
          end
        end
`ifdef CONTROLE_TIRO_RECARGA_EN
        RECARGA: if (tick && cnt_recarga <= W_REC'(1)) prox_estado = OCIOSO;
`endif
        default: prox_estado = OCIOSO;
      endcase
    end
  end

  // spawn point follows the ship while idle, then only y moves during flight
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      x_bola <= '0;
      y_bola <= '0;
    end else if (estado == OCIOSO) begin
      x_bola <= bus.x_nave + (bus.largura_nave >> 1);
      y_bola <= (bus.y_nave < RAIO_V) ? '0 : bus.y_nave - RAIO_V;
    end else if (mover) begin
      y_bola <= y_desc;
    end
  end

  // hit pulse, saturating score and enemy flag (reviver wins over a same-cycle hit)
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      acerto       <= 1'b0;
      pontuacao    <= '0;
      inimigo_vivo <= 1'b1;
    end else begin
      acerto <= evento_acerto;
      if (evento_acerto && pontuacao != PONTUACAO_MAX) pontuacao <= pontuacao + 1'b1;
      if (bus.reviver)        inimigo_vivo <= 1'b1;
      else if (evento_acerto) inimigo_vivo <= 1'b0;
    end
  end

`ifdef CONTROLE_TIRO_RECARGA_EN
  // cooldown down-counter, loaded when a shot ends, cleared by ativo low
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)                                         cnt_recarga <= '0;
    else if (!bus.ativo)                               cnt_recarga <= '0;
    else if (estado == VOANDO && prox_estado == RECARGA) cnt_recarga <= W_REC'(RECARGA_TICKS);
    else if (estado == RECARGA && tick && cnt_recarga != '0)
      cnt_recarga <= cnt_recarga - 1'b1;
  end
`endif

  assign bus.x_bola_aliada    = x_bola;
  assign bus.y_bola_aliada    = y_bola;
  assign bus.tiro_ativo       = (estado == VOANDO);
  assign bus.raio_bola_aliada = (estado == VOANDO) ? RAIO_V : '0;
  assign bus.acerto           = acerto;
  assign bus.inimigo_vivo     = inimigo_vivo;
  assign bus.pontuacao        = pontuacao;

endmodule
